// File: rtl/lcd_panel_responder_if.sv
// -----------------------------------------------------------------------------
// lcd_panel_responder_if
// Bus between the LCD driver (master) and the panel responder (slave).
//   en_i    : E strobe; a transaction executes on its falling edge
//   rw_i    : 1 = read, 0 = write
//   di_i    : 1 = data, 0 = instruction/status
//   cs_i    : active-high chip selects, bit0 = left chip, bit1 = right chip
//   db_i    : bus byte driven by the driver
//   db_o    : bus byte returned by the panel on reads
//   db_oe_o : db_o valid / drive enable
// Signal names are written from the panel's point of view.
// -----------------------------------------------------------------------------
interface lcd_panel_responder_if;
  logic       en_i;
  logic       rw_i;
  logic       di_i;
  logic [1:0] cs_i;
  logic [7:0] db_i;
  logic [7:0] db_o;
  logic       db_oe_o;

  modport master (
    output en_i, rw_i, di_i, cs_i, db_i,
    input  db_o, db_oe_o
  );

  modport slave (
    input  en_i, rw_i, di_i, cs_i, db_i,
    output db_o, db_oe_o
  );
endinterface

// File: rtl/lcd_panel_responder.sv
// -----------------------------------------------------------------------------
// lcd_panel_responder
// Panel-side model of a two-chip 128x64 graphic LCD (KS0108 style). Decodes
// the E/RS/RW/CS strobes, executes display instructions per chip, stores
// written bytes in a 1024-byte frame buffer and answers status/data reads.
// A side read port exposes the frame buffer for checking.
//
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   lcd_rst_i       : panel reset from the driver (synchronous, active-high)
//   bus             : driver bus (slave modport)
//   pix_rd_addr_i   : side port address {chip, page[2:0], col[5:0]}
//   pix_rd_data_o   : side port byte, one cycle latency
//   disp_on_o       : per-chip display-on flag
//   start_line_o    : {chip1[5:0], chip0[5:0]} display start line
//   err_o           : sticky protocol error, cleared only by rst
// -----------------------------------------------------------------------------
module lcd_panel_responder #(
  parameter int unsigned BUSY_CYCLES = 2,
  parameter logic [7:0]  FB_INIT     = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lcd_rst_i,
  lcd_panel_responder_if.slave   bus,
  input  logic [9:0]             pix_rd_addr_i,
  output logic [7:0]             pix_rd_data_o,
  output logic [1:0]             disp_on_o,
  output logic [11:0]            start_line_o,
  output logic                   err_o
);

  localparam logic [3:0] BUSY_LOAD = 4'(BUSY_CYCLES);

  // Strobe capture
  logic       r_en_q;
  logic       r_pend;
  logic       r_rw;
  logic       r_di;
  logic [1:0] r_cs;
  logic [7:0] r_db;

  // Per-chip state
  logic [5:0] r_y     [2];
  logic [2:0] r_page  [2];
  logic [5:0] r_sl    [2];
  logic [1:0] r_don;
  logic [7:0] r_latch [2];
  logic [3:0] r_busy  [2];

  // Outputs and storage
  logic [7:0] r_db_o;
  logic       r_db_oe;
  logic       r_err;
  logic [7:0] r_pix;
  logic [7:0] r_fb [1024];

  logic       w_fall;
  logic       w_instr_ok;
  logic       w_rd_chip;
  logic       w_live_chip;
  logic [1:0] w_sel;
  logic [1:0] w_go;
  logic [1:0] w_drop;
  logic [1:0] w_busy_load;
  logic [1:0] w_fb_we;
  logic [9:0] w_fb_addr [2];
  logic       w_err_ev;
  logic [7:0] w_status;
  logic [7:0] w_rd_val;

  // ---- execute-cycle decode ----
  always_comb begin
    // r_pend is cleared by lcd_rst_i, so a transaction overlapped by a panel
    // reset never executes even if E stays high afterwards.
    w_fall     = r_en_q & ~bus.en_i & r_pend & ~lcd_rst_i;
    w_instr_ok = (r_db[7:1] == 7'b0011111) | (r_db[7:6] == 2'b01) |
                 (r_db[7:3] == 5'b10111)   | (r_db[7:6] == 2'b11);
    // Reads target one chip only: chip1 for cs=10, chip0 otherwise.
    w_rd_chip  = (r_cs == 2'b10);
    w_sel      = 2'b00;
    w_go       = 2'b00;
    w_drop     = 2'b00;
    w_busy_load = 2'b00;
    w_fb_we    = 2'b00;
    for (int k = 0; k < 2; k++) begin
      // Status reads have no per-chip side effect, so they select nothing.
      w_sel[k]       = r_rw ? (r_di & r_cs[k] & (w_rd_chip == 1'(k))) : r_cs[k];
      w_go[k]        = w_fall & w_sel[k] & (r_busy[k] == 4'd0);
      w_drop[k]      = w_fall & w_sel[k] & (r_busy[k] != 4'd0);
      w_busy_load[k] = w_go[k] & ~r_rw & (r_di | w_instr_ok);
      w_fb_we[k]     = w_go[k] & ~r_rw & r_di;
      w_fb_addr[k]   = {1'(k), r_page[k], r_y[k]};
    end
    w_err_ev = w_fall & (r_cs != 2'b00) &
               ((|w_drop) | (r_rw & (r_cs == 2'b11)) | (~r_rw & ~r_di & ~w_instr_ok));

    // Read byte presented while E is high, taken from live bus selects.
    w_live_chip = (bus.cs_i == 2'b10);
    w_status    = {(r_busy[w_live_chip] != 4'd0), 1'b0, ~r_don[w_live_chip],
                   lcd_rst_i, 4'b0000};
    w_rd_val    = bus.di_i ? r_latch[w_live_chip] : w_status;
  end

  // ---- strobe tracking ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_q <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_en_q <= bus.en_i;
      if (lcd_rst_i)
        r_pend <= 1'b0;
      else if (bus.en_i && !r_en_q)
        r_pend <= 1'b1;
      else if (r_en_q && !bus.en_i)
        r_pend <= 1'b0;
    end
  end

  // ---- bus sample: the last high cycle of E wins ----
  always_ff @(posedge clk) begin
    if (bus.en_i) begin
      r_rw <= bus.rw_i;
      r_di <= bus.di_i;
      r_cs <= bus.cs_i;
      r_db <= bus.db_i;
    end
  end

  // ---- per-chip instruction / address state ----
  always_ff @(posedge clk) begin
    if (rst || lcd_rst_i) begin
      for (int k = 0; k < 2; k++) begin
        r_y[k]     <= 6'd0;
        r_page[k]  <= 3'd0;
        r_sl[k]    <= 6'd0;
        r_latch[k] <= 8'h00;
        r_busy[k]  <= 4'd0;
      end
      r_don <= 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_busy_load[k])
          r_busy[k] <= BUSY_LOAD;
        else if (r_busy[k] != 4'd0)
          r_busy[k] <= r_busy[k] - 4'd1;

        if (w_go[k]) begin
          if (r_rw) begin
            // Latch loads after the byte was driven, hence the dummy read.
            r_latch[k] <= r_fb[w_fb_addr[k]];
            r_y[k]     <= r_y[k] + 6'd1;
          end else if (r_di) begin
            r_y[k] <= r_y[k] + 6'd1;
          end else if (r_db[7:1] == 7'b0011111) begin
            r_don[k] <= r_db[0];
          end else if (r_db[7:6] == 2'b01) begin
            r_y[k] <= r_db[5:0];
          end else if (r_db[7:3] == 5'b10111) begin
            r_page[k] <= r_db[2:0];
          end else if (r_db[7:6] == 2'b11) begin
            r_sl[k] <= r_db[5:0];
          end
        end
      end
    end
  end

  // ---- bus read return and sticky error ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_o  <= 8'h00;
      r_db_oe <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_db_oe <= bus.en_i & bus.rw_i;
      if (bus.en_i && bus.rw_i)
        r_db_o <= w_rd_val;
      if (w_err_ev)
        r_err <= 1'b1;
    end
  end

  // ---- frame buffer; panel reset leaves contents intact ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++)
        r_fb[i] <= FB_INIT;
    end else begin
      for (int k = 0; k < 2; k++)
        if (w_fb_we[k])
          r_fb[w_fb_addr[k]] <= r_db;
    end
  end

  // Side port reads the pre-write value on a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst || lcd_rst_i)
      r_pix <= 8'h00;
    else
      r_pix <= r_fb[pix_rd_addr_i];
  end

  assign bus.db_o      = r_db_o;
  assign bus.db_oe_o   = r_db_oe;
  assign pix_rd_data_o = r_pix;
  assign disp_on_o     = r_don;
  assign start_line_o  = {r_sl[1], r_sl[0]};
  assign err_o         = r_err;

endmodule

// File: tb/tb_lcd_panel_responder.sv
// -----------------------------------------------------------------------------
// tb_lcd_panel_responder
// Self-checking bench: a directed vector table, hand-written multi-cycle
// sequences (busy drop, panel reset, mid-frame reset) and a randomized phase
// checked against a transaction-level model of the panel.
// -----------------------------------------------------------------------------
module tb_lcd_panel_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        lcd_rst;
  logic [9:0]  pix_addr;
  logic [7:0]  pix_data;
  logic [1:0]  disp_on;
  logic [11:0] start_line;
  logic        err;

  int total = 0;
  int bad   = 0;

  lcd_panel_responder_if bus ();

  lcd_panel_responder #(.BUSY_CYCLES(2), .FB_INIT(8'h00)) dut (
    .clk           (clk),
    .rst           (rst),
    .lcd_rst_i     (lcd_rst),
    .bus           (bus),
    .pix_rd_addr_i (pix_addr),
    .pix_rd_data_o (pix_data),
    .disp_on_o     (disp_on),
    .start_line_o  (start_line),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rw;
    logic       di;
    logic [1:0] cs;
    logic [7:0] db;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  // Transaction-level model state
  logic [7:0] m_fb [1024];
  int         m_y [2];
  int         m_page [2];
  int         m_sl [2];
  logic       m_don [2];
  logic [7:0] m_latch [2];
  logic       m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic txn(input logic rw, input logic di, input logic [1:0] cs,
                     input logic [7:0] db, input int gap,
                     output logic [7:0] rd, output logic oe);
    @(negedge clk);
    bus.en_i = 1'b1; bus.rw_i = rw; bus.di_i = di; bus.cs_i = cs; bus.db_i = db;
    @(negedge clk);
    rd = bus.db_o;
    oe = bus.db_oe_o;
    bus.en_i = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic side(input logic [9:0] a, output logic [7:0] d);
    @(negedge clk);
    pix_addr = a;
    @(negedge clk);
    d = pix_data;
  endtask

  function automatic logic [9:0] fa(input int chip, input int page, input int col);
    return 10'(chip * 512 + page * 64 + col);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_fb[i] = 8'h00;
    for (int c = 0; c < 2; c++) begin
      m_y[c] = 0; m_page[c] = 0; m_sl[c] = 0; m_don[c] = 1'b0; m_latch[c] = 8'h00;
    end
    m_err = 1'b0;
  endtask

  // Applies one complete bus transaction to the model and returns the byte
  // the panel should have presented on a read.
  task automatic model_txn(input logic rw, input logic di, input logic [1:0] cs,
                           input logic [7:0] db, output logic [7:0] rdv);
    int c;
    rdv = 8'h00;
    if (cs == 2'b00) return;
    if (rw) begin
      c = (cs == 2'b10) ? 1 : 0;
      if (cs == 2'b11) m_err = 1'b1;
      if (!di) begin
        rdv = m_don[c] ? 8'h00 : 8'h20;
      end else begin
        rdv = m_latch[c];
        m_latch[c] = m_fb[c * 512 + m_page[c] * 64 + m_y[c]];
        m_y[c] = (m_y[c] + 1) % 64;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (cs[k]) begin
          if (di) begin
            m_fb[k * 512 + m_page[k] * 64 + m_y[k]] = db;
            m_y[k] = (m_y[k] + 1) % 64;
          end else if (db == 8'h3E || db == 8'h3F) m_don[k] = db[0];
          else if (db >= 8'h40 && db <= 8'h7F) m_y[k] = db - 8'h40;
          else if (db >= 8'hB8 && db <= 8'hBF) m_page[k] = db - 8'hB8;
          else if (db >= 8'hC0) m_sl[k] = db - 8'hC0;
          else m_err = 1'b1;
        end
      end
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] sd;
    logic       oe;
    int         nerr;

    vecs[0]  = '{1'b1, 1'b0, 2'b01, 8'h00, 1'b1, 8'h20};
    vecs[1]  = '{1'b0, 1'b0, 2'b01, 8'h3F, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 2'b01, 8'h00, 1'b1, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 2'b10, 8'h00, 1'b1, 8'h20};
    vecs[4]  = '{1'b0, 1'b0, 2'b10, 8'hBB, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 2'b10, 8'h7E, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, 2'b10, 8'hAA, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 2'b10, 8'h55, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 1'b1, 2'b10, 8'h0F, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 1'b0, 2'b10, 8'hBB, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 1'b0, 2'b10, 8'h7E, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 1'b1, 2'b10, 8'h00, 1'b1, 8'h00};
    vecs[12] = '{1'b1, 1'b1, 2'b10, 8'h00, 1'b1, 8'hAA};
    vecs[13] = '{1'b1, 1'b1, 2'b10, 8'h00, 1'b1, 8'h55};
    vecs[14] = '{1'b0, 1'b0, 2'b11, 8'hD1, 1'b0, 8'h00};

    bus.en_i = 1'b0; bus.rw_i = 1'b0; bus.di_i = 1'b0; bus.cs_i = 2'b00; bus.db_i = 8'h00;
    lcd_rst = 1'b0; pix_addr = 10'd0; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset_disp_on", 32'(disp_on), 32'h0);
    chk("reset_start_line", 32'(start_line), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_db_oe", 32'(bus.db_oe_o), 32'h0);
    chk("reset_db_o", 32'(bus.db_o), 32'h0);

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      txn(vecs[i].rw, vecs[i].di, vecs[i].cs, vecs[i].db, 4, rd, oe);
      if (vecs[i].chk) chk($sformatf("vec%0d_db_o", i), 32'(rd), 32'(vecs[i].exp));
      if (i == 0) chk("vec0_db_oe", 32'(oe), 32'h1);
    end
    chk("tbl_disp_on", 32'(disp_on), 32'h1);
    chk("tbl_start_line", 32'(start_line), 32'h451);
    chk("tbl_err", 32'(err), 32'h0);
    side(fa(1, 3, 62), sd); chk("fb_1_3_62", 32'(sd), 32'hAA);
    side(fa(1, 3, 63), sd); chk("fb_1_3_63", 32'(sd), 32'h55);
    side(fa(1, 3, 0), sd);  chk("fb_1_3_0_wrap", 32'(sd), 32'h0F);
    side(fa(1, 4, 0), sd);  chk("fb_1_4_0_page_kept", 32'(sd), 32'h00);
    side(fa(0, 3, 62), sd); chk("fb_0_3_62_untouched", 32'(sd), 32'h00);

    // Panel reset held: status shows reset bit; state clears, fb survives
    @(negedge clk); lcd_rst = 1'b1;
    txn(1'b1, 1'b0, 2'b01, 8'h00, 2, rd, oe);
    chk("lcd_rst_status", 32'(rd), 32'h30);
    lcd_rst = 1'b0;
    @(negedge clk);
    chk("lcd_rst_disp_on", 32'(disp_on), 32'h0);
    chk("lcd_rst_start_line", 32'(start_line), 32'h0);
    side(fa(1, 3, 62), sd); chk("lcd_rst_fb_kept", 32'(sd), 32'hAA);

    // cs=00 is ignored without error even with an invalid code
    txn(1'b0, 1'b0, 2'b00, 8'h00, 4, rd, oe);
    chk("cs00_no_err", 32'(err), 32'h0);

    // Status read right after a write reports busy
    txn(1'b0, 1'b0, 2'b01, 8'h45, 0, rd, oe);
    txn(1'b1, 1'b0, 2'b01, 8'h00, 4, rd, oe);
    chk("busy_status", 32'(rd), 32'hA0);

    // Data write back-to-back after a write is dropped while busy
    txn(1'b0, 1'b0, 2'b01, 8'h45, 0, rd, oe);
    txn(1'b0, 1'b1, 2'b01, 8'h77, 4, rd, oe);
    side(fa(0, 0, 5), sd); chk("busy_drop_fb", 32'(sd), 32'h00);
    chk("busy_drop_err", 32'(err), 32'h1);

    // rst asserted mid-transaction
    @(negedge clk);
    bus.en_i = 1'b1; bus.rw_i = 1'b0; bus.di_i = 1'b1; bus.cs_i = 2'b11; bus.db_i = 8'h99;
    @(negedge clk);
    rst = 1'b1; bus.en_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_disp_on", 32'(disp_on), 32'h0);
    chk("rst_start_line", 32'(start_line), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    nerr = 0;
    for (int a = 0; a < 1024; a++) begin
      side(10'(a), sd);
      if (sd !== 8'h00) nerr++;
    end
    chk("rst_fb_nonzero_bytes", 32'(nerr), 32'h0);

    // Randomized phase against the model
    model_reset();
    for (int n = 0; n < 200; n++) begin
      logic       rw, di;
      logic [1:0] cs;
      logic [7:0] db, erd;
      logic [9:0] a;
      int         cls;
      rw  = ($urandom_range(0, 2) == 0);
      di  = 1'($urandom_range(0, 1));
      cs  = 2'($urandom_range(0, 3));
      cls = $urandom_range(0, 5);
      case (cls)
        0:       db = 8'h3E | 8'($urandom_range(0, 1));
        1:       db = 8'h40 | 8'($urandom_range(0, 63));
        2:       db = 8'hB8 | 8'($urandom_range(0, 7));
        3:       db = 8'hC0 | 8'($urandom_range(0, 63));
        default: db = 8'($urandom_range(0, 255));
      endcase
      txn(rw, di, cs, db, 4, rd, oe);
      model_txn(rw, di, cs, db, erd);
      if (rw && cs != 2'b00) chk($sformatf("rnd%0d_rd", n), 32'(rd), 32'(erd));
      chk($sformatf("rnd%0d_disp_on", n), 32'(disp_on), 32'({m_don[1], m_don[0]}));
      chk($sformatf("rnd%0d_start_line", n), 32'(start_line),
          32'({6'(m_sl[1]), 6'(m_sl[0])}));
      chk($sformatf("rnd%0d_err", n), 32'(err), 32'(m_err));
      if (!rw && di && cs != 2'b00)
        a = fa(cs[0] ? 0 : 1, m_page[cs[0] ? 0 : 1], (m_y[cs[0] ? 0 : 1] + 63) % 64);
      else
        a = 10'($urandom_range(0, 1023));
      side(a, sd);
      chk($sformatf("rnd%0d_fb_%0h", n, a), 32'(sd), 32'(m_fb[a]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
